// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch and data requesters share one memory port,
// data wins by default, fetch is guaranteed a slot after STARVE_LIMIT data grants.
//   state  | meaning
//   IDLE   | no transaction, arbitrating (blocked during an ack cycle)
//   GNT_IF | fetch owns the memory port, waiting for mem_ready
//   GNT_D  | data owns the memory port, waiting for mem_ready
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        stall
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            grant_d, grant_if;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_d      = 1'b0;
    grant_if     = 1'b0;

    case (state_q)
      IDLE: begin
        // The ack cycle still sees the completing requester's req high; never re-grant it.
        if (!if_ack_q && !d_ack_q) begin
          grant_d  = d_req && (!if_req || (starve_cnt_q != STARVE_MAX));
          grant_if = if_req && !grant_d;
        end
        if (grant_d) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          wait_cnt_d  = '0;
          if (if_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d      = GNT_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = if_req & ~if_ack_q;

endmodule
